// File: rtl/serdes_pkg.sv
// Shared serdes definitions: FSM state encodings used by the
// serializer and by the downstream Moore FSM.
package serdes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_PARITY = 2'b10
  } state_e;

  localparam logic [1:0] ENC_IDLE   = 2'b00;
  localparam logic [1:0] ENC_SHIFT  = 2'b01;
  localparam logic [1:0] ENC_PARITY = 2'b10;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with optional even-parity bit,
// paced by a bit-period strobe.
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter bit   PARITY_EN = 1'b0,
  parameter logic IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             bit_en,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state;
  state_e           state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh;
  logic             par;
  logic             last;
  logic             nxt_bit;
  logic             first_bit;

  function automatic logic [WIDTH-1:0] shl(
    input logic [WIDTH-1:0] v
  );
    if (MSB_FIRST)
      return {v[WIDTH-2:0], 1'b0};
    else
      return {1'b0, v[WIDTH-1:1]};
  endfunction

  assign last      = (cnt == CW'(WIDTH - 1));
  assign in_ready  = (state == ST_IDLE) && !rst;
  assign busy      = (state != ST_IDLE);
  assign nxt_bit   = MSB_FIRST ? sh[WIDTH-1]
                               : sh[0];
  assign first_bit = MSB_FIRST ? in_data[WIDTH-1]
                               : in_data[0];

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:
        if (in_valid) state_n = ST_SHIFT;
      ST_SHIFT:
        if (bit_en && last)
          state_n = PARITY_EN ? ST_PARITY
                              : ST_IDLE;
      ST_PARITY:
        if (bit_en) state_n = ST_IDLE;
      default:
        state_n = ST_IDLE;
    endcase
  end

  // sh holds the bits not yet presented; x is the bit on the wire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      sh          <= '0;
      par         <= 1'b0;
      x           <= IDLE_BIT;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      frame_start <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sh          <= shl(in_data);
            par         <= ^in_data;
            cnt         <= '0;
            x           <= first_bit;
            x_valid     <= 1'b1;
            frame_start <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bit_en) begin
            cnt <= cnt + 1'b1;
            if (!last) begin
              x  <= nxt_bit;
              sh <= shl(sh);
            end else if (PARITY_EN) begin
              x <= par;
            end else begin
              x       <= IDLE_BIT;
              x_valid <= 1'b0;
            end
          end
        end
        ST_PARITY: begin
          if (bit_en) begin
            x       <= IDLE_BIT;
            x_valid <= 1'b0;
          end
        end
        default: begin
          x       <= IDLE_BIT;
          x_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8: data word width; the block SHALL support WIDTH >= 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 = MSB shifted first, 0 = LSB shifted first.
REQ-003 Parameter PARITY_EN, default 0: 1 = append one even-parity bit after the data bits.
REQ-004 Parameter IDLE_BIT, default 1'b1: level driven on x when no frame is active.
REQ-005 clk  input  1  clock; all state SHALL update on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  in_data holds a word to send.
REQ-008 in_data  input  WIDTH  parallel word.
REQ-009 in_ready  output  1  block can accept a word this cycle.
REQ-010 bit_en  input  1  bit-period strobe; the current bit is consumed in cycles where bit_en=1.
REQ-011 x  output  1  registered serial bit stream to the downstream Moore FSM.
REQ-012 x_valid  output  1  x carries a data or parity bit.
REQ-013 frame_start  output  1  one-cycle pulse coincident with the first bit of a frame.
REQ-014 busy  output  1  frame in progress.

Function
REQ-015 The FSM SHALL have three states: IDLE, SHIFT, PARITY.
REQ-016 in_ready SHALL be 1 only in IDLE (combinational from state); busy SHALL be 1 in SHIFT or PARITY.
REQ-017 Handshake: a word SHALL be captured at the edge ending any cycle with in_valid=1 and in_ready=1; in_valid while busy SHALL be ignored and the word SHALL NOT be captured.
REQ-018 Latency: in the cycle after capture, x SHALL present the first bit, with x_valid=1, frame_start=1, and state=SHIFT.
REQ-019 Each bit SHALL be held on x until a cycle with bit_en=1; the next bit SHALL appear in the following cycle.
REQ-020 A bit counter of width $clog2(WIDTH+1) SHALL count consumed data bits; exactly WIDTH data bits SHALL be emitted per frame.
REQ-021 When the last data bit is consumed: if PARITY_EN=1, go to PARITY and present XOR of all WIDTH captured bits; otherwise go to IDLE.
REQ-022 When the parity bit is consumed, the FSM SHALL go to IDLE.
REQ-023 In IDLE: x=IDLE_BIT, x_valid=0, frame_start=0; bit_en SHALL be ignored.
REQ-024 Back-to-back frames: at least one IDLE cycle (in_ready=1) SHALL separate consecutive frames.
REQ-025 frame_start SHALL be 0 in all cycles other than the first bit cycle, including while the first bit is held waiting for bit_en.

Reset
REQ-026 While rst=1: state=IDLE, counter=0, shift register=0, x=IDLE_BIT, x_valid=0, frame_start=0, busy=0.
REQ-027 in_ready SHALL be 0 while rst=1 and 1 from the first cycle after rst deasserts.
REQ-028 On reset mid-frame, the partial frame SHALL be discarded and not resumed; the next accepted word SHALL start a complete new frame.

Structure
REQ-029 State encodings (IDLE=2'b00, SHIFT=2'b01, PARITY=2'b10) SHALL be defined in shared package serdes_pkg, which the downstream FSM package constants also use.
REQ-030 The block SHALL be one module with no sub-module: one sequential process for state, counter, and shift register, and one combinational process for next-state logic; parity SHALL be an XOR reduction.

Verification
REQ-031 Reset: rst=1 at arbitrary time -> x=1, x_valid=0, busy=0, in_ready=0; after release, in_ready=1 next cycle.
REQ-032 WIDTH=8, MSB_FIRST=1, bit_en=1 constantly, load 8'hA5 -> x=1,0,1,0,0,1,0,1 over 8 consecutive cycles, frame_start on the first only, then x=1, x_valid=0, in_ready=1.
REQ-033 MSB_FIRST=0, bit_en every third cycle, load 8'h01 -> first bit 1 then seven 0s, each held until its bit_en cycle; 8 bit_en strobes total per frame.
REQ-034 PARITY_EN=1, load 8'h07 -> 8 data bits (LSB/MSB per parameter) followed by parity bit 1 with x_valid=1; then IDLE.
REQ-035 in_valid=1 with 8'hFF held during a frame of 8'h00 -> output stays all 0s; 8'hFF is accepted only in the next IDLE cycle.
REQ-036 rst pulsed after 3 bits of 8'hA5 -> x=IDLE_BIT and x_valid=0 immediately; a subsequent load of 8'h3C emits all 8 bits correctly.
